// File: rtl/sparse_conv_pkg.sv
// Shared geometry, state encoding and saturating arithmetic for the
// sparse-convolution partial-sum path.
package sparse_conv_pkg;

  localparam int unsigned ROW_LENGTH  = 28;
  localparam int unsigned FILTER_SIZE = 5;
  localparam int unsigned OUT_LEN     = ROW_LENGTH - FILTER_SIZE + 1;
  localparam int unsigned PROD_W      = 16;
  localparam int unsigned IDX_W       = 8;
  localparam int unsigned ACC_W       = 24;
  localparam int unsigned PTR_W       = $clog2(OUT_LEN);
  localparam int unsigned DROP_W      = 8;

  typedef enum logic {
    ACCUM,
    DRAIN
  } state_t;

  typedef struct packed {
    logic             ovf;
    logic [ACC_W-1:0] sum;
  } sat_res_t;

  // Unsigned add of a zero-extended product; clamps to all-ones on carry-out.
  function automatic sat_res_t sat_add(input logic [ACC_W-1:0]  a,
                                       input logic [PROD_W-1:0] b);
    sat_res_t       r;
    logic [ACC_W:0] full;
    full  = {1'b0, a} + {{(ACC_W - PROD_W + 1){1'b0}}, b};
    r.ovf = full[ACC_W];
    r.sum = full[ACC_W] ? '1 : full[ACC_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/psum_scatter_acc_if.sv
// Product input stream and drained partial-sum output stream.
interface psum_scatter_acc_if;

  logic                               prod_valid;
  logic [sparse_conv_pkg::PROD_W-1:0] prod;
  logic [sparse_conv_pkg::IDX_W-1:0]  prod_idx;
  logic                               row_done;
  logic                               in_ready;
  logic                               acc_valid;
  logic                               acc_ready;
  logic [sparse_conv_pkg::ACC_W-1:0]  acc_data;
  logic [sparse_conv_pkg::IDX_W-1:0]  acc_idx;
  logic                               acc_last;
  logic                               acc_sat;

  // Producer of pairs and consumer of drained sums.
  modport master (
    output prod_valid, prod, prod_idx, row_done, acc_ready,
    input  in_ready, acc_valid, acc_data, acc_idx, acc_last, acc_sat
  );

  // The accumulator block.
  modport slave (
    input  prod_valid, prod, prod_idx, row_done, acc_ready,
    output in_ready, acc_valid, acc_data, acc_idx, acc_last, acc_sat
  );

endinterface

// File: rtl/psum_bank.sv
// OUT_LEN x ACC_W partial-sum flop bank: one saturating read-modify-write
// add port and one read-and-clear port.
module psum_bank
  import sparse_conv_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             add_en,
  input  logic [PTR_W-1:0] add_ptr,
  input  logic [PROD_W-1:0] add_val,
  output logic             add_ovf,
  input  logic [PTR_W-1:0] rd_ptr,
  input  logic             clr_en,
  output logic [ACC_W-1:0] rd_data
);

  logic [ACC_W-1:0] bank [OUT_LEN];
  sat_res_t         add_res;

  // Read side. The RMW reads the flops directly: a write lands on the clock
  // edge, so a same-index pair in the very next cycle already sees it.
  always_comb begin
    add_res = sat_add(bank[add_ptr], add_val);
    add_ovf = add_en & add_res.ovf;
    rd_data = bank[rd_ptr];
  end

  // Per-entry update; clear wins over add (they never coincide in practice).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < OUT_LEN; i++) bank[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < OUT_LEN; i++) begin
        if (clr_en && rd_ptr == PTR_W'(i))
          bank[i] <= '0;
        else if (add_en && add_ptr == PTR_W'(i))
          bank[i] <= add_res.sum;
      end
    end
  end

endmodule

// File: rtl/psum_scatter_acc.sv
// Scatter-accumulates (product, index) pairs into one output row, then drains
// the row densely over valid/ready, clearing each entry as it leaves.
module psum_scatter_acc
  import sparse_conv_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  psum_scatter_acc_if.slave      bus,
  output logic [DROP_W-1:0]      drop_cnt
);

  state_t           state, state_nxt;
  logic [PTR_W-1:0] drain_ptr;
  logic             sat_row;
  logic             in_range;
  logic             accept;
  logic             add_en;
  logic             drop;
  logic             add_ovf;
  logic             hs;
  logic             last_ptr;
  logic             last_hs;
  logic [ACC_W-1:0] rd_data;

  assign in_range = bus.prod_idx < IDX_W'(OUT_LEN);
  assign accept   = bus.prod_valid & bus.in_ready;
  assign add_en   = accept & in_range;
  assign drop     = accept & ~in_range;
  assign hs       = bus.acc_valid & bus.acc_ready;
  assign last_ptr = drain_ptr == PTR_W'(OUT_LEN - 1);
  assign last_hs  = hs & last_ptr;

  assign bus.acc_data = rd_data;
  assign bus.acc_idx  = {{(IDX_W - PTR_W){1'b0}}, drain_ptr};
  assign bus.acc_last = (state == DRAIN) & last_ptr;
  assign bus.acc_sat  = sat_row & bus.acc_last;

  psum_bank u_bank (
    .clk     (clk),
    .rst     (rst),
    .add_en  (add_en),
    .add_ptr (bus.prod_idx[PTR_W-1:0]),
    .add_val (bus.prod),
    .add_ovf (add_ovf),
    .rd_ptr  (drain_ptr),
    .clr_en  (hs),
    .rd_data (rd_data)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.acc_valid = 1'b0;
    case (state)
      ACCUM: begin
        bus.in_ready = 1'b1;
        if (bus.row_done) state_nxt = DRAIN;
      end
      DRAIN: begin
        bus.acc_valid = 1'b1;
        if (last_hs) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  // Drain pointer advances per accepted beat and wraps after the last one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          drain_ptr <= '0;
    else if (last_hs) drain_ptr <= '0;
    else if (hs)      drain_ptr <= drain_ptr + 1'b1;
  end

  // Sticky per-row saturation flag, released when the row finishes draining.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          sat_row <= 1'b0;
    else if (last_hs) sat_row <= 1'b0;
    else if (add_ovf) sat_row <= 1'b1;
  end

  // Saturating count of out-of-range pairs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      drop_cnt <= '0;
    else if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
  end

endmodule

// File: tb/tb_psum_scatter_acc.sv
// Scoreboard bench: stimulus pushes expected drain beats, a negedge monitor
// pops and compares them on each handshake and checks hold during stalls.
module tb_psum_scatter_acc;
  import sparse_conv_pkg::*;

  typedef struct {
    logic [ACC_W-1:0] data;
    logic [IDX_W-1:0] idx;
    logic             last;
    logic             sat;
  } beat_t;

  logic               clk;
  logic               rst;
  logic [DROP_W-1:0]  drop_cnt;
  psum_scatter_acc_if bus ();

  beat_t            q [$];
  beat_t            mon_e;
  logic [ACC_W-1:0] exp_row [OUT_LEN];
  int               pass_cnt  = 0;
  int               total_cnt = 0;

  psum_scatter_acc dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .drop_cnt (drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    total_cnt++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Monitor: compare presented beat against head of scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.acc_valid) begin
      if (q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_beat: got idx %0d expected none", bus.acc_idx);
      end else begin
        mon_e = q[0];
        chk("acc_idx",  32'(bus.acc_idx),  32'(mon_e.idx));
        chk("acc_data", 32'(bus.acc_data), 32'(mon_e.data));
        chk("acc_last", 32'(bus.acc_last), 32'(mon_e.last));
        chk("acc_sat",  32'(bus.acc_sat),  32'(mon_e.sat));
        if (bus.acc_ready) q.delete(0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pair(input logic [PROD_W-1:0] p, input logic [IDX_W-1:0] i);
    bus.prod_valid = 1'b1;
    bus.prod       = p;
    bus.prod_idx   = i;
    step();
    bus.prod_valid = 1'b0;
  endtask

  task automatic send_row_done();
    bus.row_done = 1'b1;
    step();
    bus.row_done = 1'b0;
  endtask

  task automatic expect_row(input logic sat);
    beat_t b;
    for (int i = 0; i < OUT_LEN; i++) begin
      b.data = exp_row[i];
      b.idx  = IDX_W'(i);
      b.last = (i == OUT_LEN - 1);
      b.sat  = sat && (i == OUT_LEN - 1);
      q.push_back(b);
      exp_row[i] = '0;
    end
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      step();
      if (q.size() == 0 && bus.in_ready) done = 1'b1;
    end
    if (!done) fail_now(name);
  endtask

  initial begin
    bit       done;
    bit [3:0] pat;
    pat = 4'b1001;
    for (int i = 0; i < OUT_LEN; i++) exp_row[i] = '0;
    rst            = 1'b1;
    bus.prod_valid = 1'b0;
    bus.prod       = '0;
    bus.prod_idx   = '0;
    bus.row_done   = 1'b0;
    bus.acc_ready  = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();

    // Reset state
    chk("rst_acc_valid", 32'(bus.acc_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_acc_idx",   32'(bus.acc_idx),   32'd0);
    chk("rst_acc_last",  32'(bus.acc_last),  32'd0);
    chk("rst_acc_sat",   32'(bus.acc_sat),   32'd0);
    chk("rst_drop_cnt",  32'(drop_cnt),      32'd0);

    // T1: back-to-back same index, last index in range
    send_pair(16'd10, 8'd0);
    send_pair(16'd20, 8'd0);
    send_pair(16'd5,  8'd23);
    exp_row[0]  = 24'd30;
    exp_row[23] = 24'd5;
    expect_row(1'b0);
    bus.acc_ready = 1'b1;
    send_row_done();
    wait_drain("t1_drain");

    // T2: out-of-range pairs dropped, boundary idx 24
    send_pair(16'd7, 8'd30);
    send_pair(16'd3, 8'd24);
    chk("t2_drop_cnt", 32'(drop_cnt), 32'd2);
    expect_row(1'b0);
    send_row_done();
    wait_drain("t2_drain");
    send_pair(16'd1, 8'd0);
    exp_row[0] = 24'd1;
    expect_row(1'b0);
    send_row_done();
    wait_drain("t2b_drain");

    // T3: saturation and sticky flag cleared for next row
    for (int k = 0; k < 300; k++) send_pair(16'hFFFF, 8'd4);
    exp_row[4] = 24'hFFFFFF;
    expect_row(1'b1);
    send_row_done();
    wait_drain("t3_drain");
    expect_row(1'b0);
    send_row_done();
    wait_drain("t3b_drain");

    // T4: stalled drain with upstream holding a pair
    send_pair(16'd11, 8'd1);
    send_pair(16'd12, 8'd2);
    send_pair(16'd13, 8'd22);
    exp_row[1]  = 24'd11;
    exp_row[2]  = 24'd12;
    exp_row[22] = 24'd13;
    expect_row(1'b0);
    bus.acc_ready = 1'b0;
    send_row_done();
    bus.prod_valid = 1'b1;
    bus.prod       = 16'd100;
    bus.prod_idx   = 8'd3;
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      bus.acc_ready = pat[c % 4];
      step();
      if (q.size() == 0 && bus.in_ready) done = 1'b1;
      else chk("t4_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.prod_valid = 1'b0;
    if (!done) fail_now("t4_drain");

    // T5: pair together with row_done; held pair above must not have landed
    bus.acc_ready  = 1'b0;
    bus.prod_valid = 1'b1;
    bus.prod       = 16'd9;
    bus.prod_idx   = 8'd2;
    bus.row_done   = 1'b1;
    exp_row[2]     = 24'd9;
    expect_row(1'b0);
    step();
    bus.prod_valid = 1'b0;
    bus.row_done   = 1'b0;
    chk("t5_in_ready",  32'(bus.in_ready),  32'd0);
    chk("t5_acc_valid", 32'(bus.acc_valid), 32'd1);
    bus.acc_ready = 1'b1;
    wait_drain("t5_drain");

    // T6: reset after beat idx5
    send_pair(16'd42, 8'd7);
    exp_row[7] = 24'd42;
    expect_row(1'b0);
    send_row_done();
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      step();
      if (q.size() <= OUT_LEN - 6) done = 1'b1;
    end
    if (!done) fail_now("t6_wait");
    rst           = 1'b1;
    bus.acc_ready = 1'b0;
    q.delete();
    #1;
    chk("t6_acc_valid", 32'(bus.acc_valid), 32'd0);
    chk("t6_in_ready",  32'(bus.in_ready),  32'd1);
    chk("t6_acc_idx",   32'(bus.acc_idx),   32'd0);
    chk("t6_drop_cnt",  32'(drop_cnt),      32'd0);
    step();
    rst = 1'b0;
    step();
    expect_row(1'b0);
    bus.acc_ready = 1'b1;
    send_row_done();
    wait_drain("t6_drain");

    // drop counter saturation boundary
    for (int k = 0; k < 254; k++) send_pair(16'd1, 8'd255);
    chk("drop_254", 32'(drop_cnt), 32'd254);
    for (int k = 0; k < 3; k++) send_pair(16'd1, 8'd200);
    chk("drop_sat", 32'(drop_cnt), 32'd255);

    step();
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
